// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// Holds the FSM state enum, command encodings, frame width and a command check helper.
package spi_pkg;

   localparam int FRAME_W = 10;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   // True when the frame command matches the path the FSM took.
   function automatic logic cmd_match(input state_t s, input logic [1:0] cmd);
      logic ok;
      ok = 1'b0;
      case (s)
         WRITE:     ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
         READ_ADD:  ok = (cmd == CMD_RD_ADDR);
         READ_DATA: ok = (cmd == CMD_RD_DATA);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser for RAM read data.
// Ports: clk, rst (async high), clr (sync abort), load, din -> bit_out, done (last-bit edge).
module spi_tx_shifter
   import spi_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic         bit_out,
   output logic         done
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [W-1:0]  sr;
   logic [CW-1:0] cnt;
   logic          active;

   assign bit_out = active & sr[W-1];
   // High during the cycle showing the final bit; the next edge ends transmission.
   assign done = active & (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr     <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (clr) begin
         sr     <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (load) begin
         sr     <= din;
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         if (done) begin
            sr     <= '0;
            cnt    <= '0;
            active <= 1'b0;
         end else begin
            sr  <= {sr[W-2:0], 1'b0};
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: MOSI frames -> rx_data/rx_valid, RAM read data -> MISO.
// Ports: clk, rst, SS_n, MOSI, MISO, rx_data, rx_valid, tx_data, tx_valid, err.
// Optional macro SPI_SLAVE_CMD_CHECK_EN enables command/path checking on err.
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SS_n,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic [DATA_WIDTH+1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  err
);

   localparam int FW = DATA_WIDTH + 2;
   localparam logic [3:0] BIT0_CNT = 4'(FW - 2);
   localparam logic [3:0] DONE_CNT = 4'(FW - 1);

   state_t        state_q;
   state_t        state_d;
   logic [FW-2:0] rx_sr;
   logic [3:0]    cnt;
   logic          rd_addr_ok;
   logic          tx_wait;
   logic          tx_load;
   logic          tx_done;
   logic          rx_phase;
   logic          frame_end;
   logic          frame_ok;
   logic [FW-1:0] frame;

   assign rx_phase = (state_q == WRITE) || (state_q == READ_ADD) ||
                     (state_q == READ_DATA);
   assign frame = {rx_sr, MOSI};
   // Abort wins over a simultaneous bit-0 sample.
   assign frame_end = rx_phase && !SS_n && (cnt == BIT0_CNT);

`ifdef SPI_SLAVE_CMD_CHECK_EN
   assign frame_ok = cmd_match(state_q, frame[FW-1:FW-2]);
`else
   assign frame_ok = 1'b1;
`endif

   // tx_valid only counts between a good READ_DATA frame and the load.
   assign tx_load = (state_q == READ_DATA) && tx_wait && tx_valid && !SS_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (SS_n) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = CHK_CMD;
            CHK_CMD: begin
               if (!MOSI)          state_d = WRITE;
               else if (rd_addr_ok) state_d = READ_DATA;
               else                 state_d = READ_ADD;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sr      <= '0;
         cnt        <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rd_addr_ok <= 1'b0;
         tx_wait    <= 1'b0;
      end else begin
         rx_valid <= frame_end & frame_ok;
         if (frame_end) rx_data <= frame;

         if (SS_n) begin
            rx_sr <= '0;
            cnt   <= '0;
         end else if (state_q == CHK_CMD) begin
            rx_sr <= {rx_sr[FW-3:0], MOSI};
            cnt   <= '0;
         end else if (rx_phase && (cnt != DONE_CNT)) begin
            rx_sr <= {rx_sr[FW-3:0], MOSI};
            cnt   <= cnt + 4'd1;
         end

         if (SS_n || tx_load)
            tx_wait <= 1'b0;
         else if (frame_end && frame_ok && (state_q == READ_DATA))
            tx_wait <= 1'b1;

         if (frame_end && frame_ok && (state_q == READ_ADD))
            rd_addr_ok <= 1'b1;
         else if (tx_done && !SS_n)
            rd_addr_ok <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_CMD_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= frame_end & ~frame_ok;
   end
`else
   assign err = 1'b0;
`endif

   spi_tx_shifter #(
      .W (DATA_WIDTH)
   ) u_tx (
      .clk     (clk),
      .rst     (rst),
      .clr     (SS_n),
      .load    (tx_load),
      .din     (tx_data),
      .bit_out (MISO),
      .done    (tx_done)
   );

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed self-checking bench for spi_slave_ctrl.
// Drives and samples on the falling clock edge.
module tb_spi_slave_ctrl;
   import spi_pkg::*;

   logic       clk;
   logic       rst;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       err;

   int checks;
   int failures;
   int rxv_cnt;
   int err_cnt;

   spi_slave_ctrl #(.DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) rxv_cnt++;
      if (err) err_cnt++;
   end

   // Drive SS_n low then the first n frame bits, MSB first.
   task automatic shift_bits(input logic [9:0] f, input int n);
      @(negedge clk);
      SS_n = 1'b0;
      for (int i = 9; i > 9 - n; i--) begin
         @(negedge clk);
         MOSI = f[i];
      end
   endtask

   task automatic end_frame();
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      SS_n = 1'b1;
      MOSI = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({MISO, rx_valid, err, rx_data} !== 13'h0) begin
         failures++;
         $display("FAIL reset_out got %b want 0", {MISO, rx_valid, err, rx_data});
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE);
      end
      rst = 1'b0;
      shift_bits(10'h2AB, 10);
      @(negedge clk);
      checks++;
      if (rx_data !== 10'h2AB || rx_valid !== 1'b1 || dut.rd_addr_ok !== 1'b1) begin
         failures++;
         $display("FAIL pre_rst_frame got %h/%b/%b want 2ab/1/1",
                  rx_data, rx_valid, dut.rd_addr_ok);
      end
      end_frame();
      shift_bits(10'h3C0, 4);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({MISO, rx_valid, err, rx_data} !== 13'h0 || dut.state_q !== IDLE ||
          dut.rd_addr_ok !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst got %b st=%0d ok=%b want 0/IDLE/0",
                  {MISO, rx_valid, err, rx_data}, dut.state_q, dut.rd_addr_ok);
      end
      @(negedge clk);
      rst = 1'b0;
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      int base;
      base = rxv_cnt;
      shift_bits(10'h005, 9);
      tx_data = 8'hFF;
      tx_valid = 1'b1;
      @(negedge clk);
      MOSI = 1'b1;
      checks++;
      if (rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL wr_early got %b want 0", rx_valid);
      end
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 10'h005) begin
         failures++;
         $display("FAIL wr_frame1 got %b/%h want 1/005", rx_valid, rx_data);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      checks++;
      if (rx_valid !== 1'b0 || MISO !== 1'b0) begin
         failures++;
         $display("FAIL wr_pulse got v=%b miso=%b want 0/0", rx_valid, MISO);
      end
      end_frame();
      shift_bits(10'h1AA, 10);
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 10'h1AA) begin
         failures++;
         $display("FAIL wr_frame2 got %b/%h want 1/1aa", rx_valid, rx_data);
      end
      end_frame();
      checks++;
      if (rxv_cnt - base !== 2) begin
         failures++;
         $display("FAIL wr_count got %0d want 2", rxv_cnt - base);
      end
   endtask

   task automatic test_read(input logic [9:0] rd_frame, input logic [7:0] d);
      shift_bits(10'h205, 10);
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 10'h205 || dut.rd_addr_ok !== 1'b1) begin
         failures++;
         $display("FAIL rd_addr got %b/%h ok=%b want 1/205/1",
                  rx_valid, rx_data, dut.rd_addr_ok);
      end
      end_frame();
      shift_bits(rd_frame, 10);
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== rd_frame || MISO !== 1'b0) begin
         failures++;
         $display("FAIL rd_cmd got %b/%h miso=%b want 1/%h/0",
                  rx_valid, rx_data, MISO, rd_frame);
      end
      tx_data = d;
      tx_valid = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         tx_valid = 1'b0;
         tx_data = 8'h00;
         checks++;
         if (MISO !== d[i]) begin
            failures++;
            $display("FAIL rd_miso bit%0d got %b want %b", i, MISO, d[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (MISO !== 1'b0 || dut.rd_addr_ok !== 1'b0) begin
         failures++;
         $display("FAIL rd_tail got miso=%b ok=%b want 0/0", MISO, dut.rd_addr_ok);
      end
      end_frame();
   endtask

   task automatic test_abort();
      int base;
      base = rxv_cnt;
      shift_bits(10'h3FF, 5);
      end_frame();
      repeat (3) @(negedge clk);
      checks++;
      if (rxv_cnt !== base) begin
         failures++;
         $display("FAIL abort_5 got %0d pulses want 0", rxv_cnt - base);
      end
      shift_bits(10'h0F1, 9);
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rxv_cnt !== base) begin
         failures++;
         $display("FAIL abort_bit0 got %0d pulses want 0", rxv_cnt - base);
      end
      shift_bits(10'h0F0, 10);
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 10'h0F0) begin
         failures++;
         $display("FAIL abort_next got %b/%h want 1/0f0", rx_valid, rx_data);
      end
      end_frame();
   endtask

   task automatic test_back_to_back();
      shift_bits(10'h201, 10);
      end_frame();
      shift_bits(10'h0C3, 10);
      @(negedge clk);
      checks++;
      if (rx_data !== 10'h0C3 || dut.rd_addr_ok !== 1'b1) begin
         failures++;
         $display("FAIL keep_ok got %h ok=%b want 0c3/1", rx_data, dut.rd_addr_ok);
      end
      end_frame();
      shift_bits(10'h300, 3);
      checks++;
      if (dut.state_q !== READ_DATA) begin
         failures++;
         $display("FAIL keep_path got %0d want %0d", dut.state_q, READ_DATA);
      end
      end_frame();
      test_read(10'h3A5, 8'h5C);
   endtask

   task automatic test_cmd_check();
      int rb;
      int eb;
      shift_bits(10'h2AA, 10);
      end_frame();
      rb = rxv_cnt;
      eb = err_cnt;
      shift_bits(10'h255, 10);
      @(negedge clk);
      repeat (2) @(negedge clk);
`ifdef SPI_SLAVE_CMD_CHECK_EN
      checks++;
      if (rxv_cnt - rb !== 0 || err_cnt - eb !== 1 || dut.rd_addr_ok !== 1'b1) begin
         failures++;
         $display("FAIL cmd_chk got v=%0d e=%0d ok=%b want 0/1/1",
                  rxv_cnt - rb, err_cnt - eb, dut.rd_addr_ok);
      end
`else
      checks++;
      if (rxv_cnt - rb !== 1 || err_cnt - eb !== 0 || rx_data !== 10'h255) begin
         failures++;
         $display("FAIL cmd_nochk got v=%0d e=%0d d=%h want 1/0/255",
                  rxv_cnt - rb, err_cnt - eb, rx_data);
      end
`endif
      end_frame();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rxv_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_write();
      test_read(10'h3FF, 8'hAA);
      test_abort();
      test_back_to_back();
      test_cmd_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

- SPI slave front end feeding the single-port RAM: deserialises MOSI into 10-bit command frames (`rx_data`, `rx_valid`) and serialises RAM read data (`tx_data`, `tx_valid`) back onto MISO.
- MOSI, SS_n and MISO are handled on the system clock. The SPI master is guaranteed to be slower than, and synchronous to, `clk`.
- Sits directly upstream of the RAM. `rx_data`/`rx_valid` connect to RAM `din`/`rx_valid`; RAM `dout`/`tx_valid` connect back to `tx_data`/`tx_valid`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: RAM word / address width. Frame width is `DATA_WIDTH+2`.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `SS_n`  in  1: slave select, active-low; high aborts any transaction.
- `MOSI`  in  1: serial data in, MSB first.
- `MISO`  out  1: serial data out, MSB first.
- `rx_data`  out  DATA_WIDTH+2: completed frame `{cmd[1:0], payload}`.
- `rx_valid`  out  1: single-cycle strobe, `rx_data` valid.
- `tx_data`  in  DATA_WIDTH: RAM read data.
- `tx_valid`  in  1: `tx_data` valid this cycle.
- `err`  out  1: single-cycle command-mismatch strobe. Only active with the configuration macro; otherwise tied 0.

## Operation
- **States:**
  - IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - Internal flag `rd_addr_ok`, reset 0.
- **IDLE:**
  - On `SS_n`=0, go to CHK_CMD. No bit is consumed.
- **CHK_CMD:**
  - `MOSI` this cycle is frame bit 9 and is shifted in.
  - 0 → WRITE.
  - 1 and `rd_addr_ok`=0 → READ_ADD.
  - 1 and `rd_addr_ok`=1 → READ_DATA.
- **WRITE / READ_ADD / READ_DATA, receive phase:**
  - Shift in the remaining 9 bits (bits 8..0), one per cycle, MSB first.
  - 4-bit counter tracks bits.
  - On the edge that samples bit 0, register the frame into `rx_data` and set `rx_valid`=1 for exactly one cycle.
- **READ_ADD:** on frame completion set `rd_addr_ok`=1, then hold until `SS_n`=1.
- **READ_DATA, transmit phase:**
  - After `rx_valid`, wait for `tx_valid`=1.
  - On that edge, latch `tx_data` into the TX shift register.
  - Drive `MISO` with bits 7..0 over the next 8 cycles.
  - Then `MISO`=0, clear `rd_addr_ok`, hold until `SS_n`=1.
  - `tx_valid` seen outside this wait window is ignored.
- **Any state, `SS_n`=1:** next state IDLE.
  - Counters and TX shift register are cleared.
  - A partial frame produces no `rx_valid`.
  - `rd_addr_ok` is unchanged.
- **`MISO`** is 0 whenever the block is not in the transmit phase.

## Timing
- **Reset values:**
  - `MISO`=0, `rx_data`=0, `rx_valid`=0, `err`=0.
  - State IDLE, `rd_addr_ok`=0.
- **Frame latency:**
  - `SS_n` low sampled at edge E0.
  - Bit 9 sampled at E1, bit 0 at E10.
  - `rx_valid` high during the cycle after E10.
- **Read latency:**
  - `tx_valid` sampled at edge T0.
  - `MISO` = `tx_data[7]` after T0, through to `tx_data[0]` after T7, then 0 after T8.
- **Simultaneous `SS_n` rise and bit-0 sample:** abort wins; no `rx_valid`.
- **`rst` mid-frame:** immediate return to reset values.
- **Back-to-back frames:** require `SS_n` high for ≥1 cycle between them.

## Configuration
- Macro: `SPI_SLAVE_CMD_CHECK_EN`.
- **Defined:**
  - On frame completion, check `rx_data[9:8]` against the path: WRITE accepts 00/01, READ_ADD 10, READ_DATA 11.
  - Mismatch: suppress `rx_valid`, pulse `err` for one cycle, and make no `rd_addr_ok` change.
- **Undefined:** no check; `err` tied 0.

## Structure
- Package `spi_pkg` holds:
  - state enum typedef;
  - command encodings `CMD_WR_ADDR`=00, `CMD_WR_DATA`=01, `CMD_RD_ADDR`=10, `CMD_RD_DATA`=11;
  - `FRAME_W` localparam.
- Sub-module `spi_tx_shifter` does the parallel-load, MSB-first serialiser with done flag.
- Top module keeps the FSM, RX shift register and counter.

## Test plan
- **Reset:** assert `rst` mid-frame → all outputs 0, state IDLE within the same cycle.
- **Write frame:** `SS_n`=0, MOSI 00_0000_0101 → `rx_data`=0x005, one-cycle `rx_valid`; then MOSI 01_1010_1010 in a new frame → `rx_data`=0x1AA.
- **Read sequence:**
  - Frame 10_0000_0101 → `rx_data`=0x205, `rd_addr_ok` set.
  - Next frame 11_xxxx_xxxx, with `tx_valid`=1 and `tx_data`=0xAA → MISO 1,0,1,0,1,0,1,0 over 8 cycles, then 0.
- **Abort:** raise `SS_n` after 5 bits → no `rx_valid`; next full frame decodes correctly.
- **Read-address state retained:** a write frame between read-address and read-data leaves `rd_addr_ok`=1, and the following read goes to READ_DATA.
- **With `SPI_SLAVE_CMD_CHECK_EN`:** first bit 0 with `rx_data[9:8]`=10 is impossible, so instead send a READ_DATA-path frame 10_xxxx → `err` pulses once, no `rx_valid`.
